// File: rtl/clock_set_ctrl.sv
// Time-setting controller: walks hour/minute/second edit states from debounced
// buttons, with auto-repeat stepping, idle timeout and a one-cycle PE commit.
module clock_set_ctrl #(
  parameter int unsigned HOLD_CYCLES    = 8,
  parameter int unsigned REPEAT_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       _CR,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic [7:0] show_hour,
  input  logic [7:0] show_min,
  input  logic [7:0] show_sec,
  output logic [7:0] pre_hour,
  output logic [7:0] pre_min,
  output logic [7:0] pre_sec,
  output logic       PE,
  output logic       run_en,
  output logic [1:0] edit_field
);

  localparam int unsigned REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam int unsigned IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [REP_W-1:0]  HOLD_L    = REP_W'(HOLD_CYCLES);
  localparam logic [REP_W-1:0]  REPEAT_L  = REP_W'(REPEAT_CYCLES);
  localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  typedef enum logic [2:0] {
    S_RUN,
    S_SET_HOUR,
    S_SET_MIN,
    S_SET_SEC,
    S_COMMIT
  } state_t;

  state_t r_state, w_state_nxt;

  logic r_mode_q, r_mode_d, r_inc_q, r_inc_d, r_dec_q, r_dec_d;
  logic [REP_W-1:0]  r_rep_cnt, w_rep_nxt;
  logic [IDLE_W-1:0] r_idle, w_idle_nxt;
  logic [7:0] r_pre_hour, r_pre_min, r_pre_sec;
  logic [7:0] w_hour_nxt, w_min_nxt, w_sec_nxt;
  logic       r_pe, r_run_en, w_pe_nxt, w_run_en_nxt;
  logic [1:0] r_edit, w_edit_nxt;

  logic w_mode_edge, w_inc_edge, w_dec_edge;
  logic w_step, w_up, w_active, w_timeout, w_editing;

  assign w_mode_edge = r_mode_q & ~r_mode_d;
  assign w_inc_edge  = r_inc_q & ~r_inc_d;
  assign w_dec_edge  = r_dec_q & ~r_dec_d;

  // Out-of-range values behave as the maximum: up goes to 0, down to max-1.
  function automatic logic [7:0] f_step(input logic [7:0] v, input logic [7:0] maxv,
                                        input logic up);
    if (up)             return (v >= maxv) ? 8'd0 : v + 8'd1;
    else if (v == 8'd0) return maxv;
    else if (v > maxv)  return maxv - 8'd1;
    else                return v - 8'd1;
  endfunction

  // Repeat counter: loaded with HOLD on the edge step, reloaded with REPEAT
  // on each repeat step; a step fires whenever it would expire.
  always_comb begin
    w_step    = 1'b0;
    w_rep_nxt = r_rep_cnt;
    if (r_inc_q == r_dec_q) begin
      w_rep_nxt = '0;
    end else if (w_inc_edge || w_dec_edge) begin
      w_step    = 1'b1;
      w_rep_nxt = HOLD_L;
    end else if (r_rep_cnt == REP_ONE) begin
      w_step    = 1'b1;
      w_rep_nxt = REPEAT_L;
    end else if (r_rep_cnt != '0) begin
      w_rep_nxt = r_rep_cnt - REP_ONE;
    end
  end

  assign w_up      = r_inc_q;
  assign w_editing = (r_state == S_SET_HOUR) || (r_state == S_SET_MIN) || (r_state == S_SET_SEC);
  assign w_active  = w_mode_edge | w_step | r_mode_q | r_inc_q | r_dec_q;
  assign w_timeout = w_editing && !w_active && (r_idle == IDLE_LAST);

  always_comb begin
    w_idle_nxt = '0;
    if (w_editing && !w_active && !w_timeout) w_idle_nxt = r_idle + IDLE_ONE;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hour_nxt  = r_pre_hour;
    w_min_nxt   = r_pre_min;
    w_sec_nxt   = r_pre_sec;
    case (r_state)
      S_RUN: begin
        if (w_mode_edge) begin
          w_state_nxt = S_SET_HOUR;
          w_hour_nxt  = show_hour;
          w_min_nxt   = show_min;
          w_sec_nxt   = show_sec;
        end
      end
      S_SET_HOUR: begin
        if (w_mode_edge)    w_state_nxt = S_SET_MIN;
        else if (w_timeout) w_state_nxt = S_RUN;
        else if (w_step)    w_hour_nxt  = f_step(r_pre_hour, 8'd23, w_up);
      end
      S_SET_MIN: begin
        if (w_mode_edge)    w_state_nxt = S_SET_SEC;
        else if (w_timeout) w_state_nxt = S_RUN;
        else if (w_step)    w_min_nxt   = f_step(r_pre_min, 8'd59, w_up);
      end
      S_SET_SEC: begin
        if (w_mode_edge)    w_state_nxt = S_COMMIT;
        else if (w_timeout) w_state_nxt = S_RUN;
        else if (w_step)    w_sec_nxt   = f_step(r_pre_sec, 8'd59, w_up);
      end
      S_COMMIT: w_state_nxt = S_RUN;
      default:  w_state_nxt = S_RUN;
    endcase
  end

  // Outputs are decoded from the next state so they update with it.
  always_comb begin
    w_pe_nxt     = 1'b0;
    w_run_en_nxt = 1'b0;
    w_edit_nxt   = 2'd0;
    case (w_state_nxt)
      S_RUN:      w_run_en_nxt = 1'b1;
      S_SET_HOUR: w_edit_nxt   = 2'd1;
      S_SET_MIN:  w_edit_nxt   = 2'd2;
      S_SET_SEC:  w_edit_nxt   = 2'd3;
      S_COMMIT:   w_pe_nxt     = 1'b1;
      default:    w_run_en_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge _CR) begin
    if (!_CR) begin
      r_state    <= S_RUN;
      r_mode_q   <= 1'b0;
      r_mode_d   <= 1'b0;
      r_inc_q    <= 1'b0;
      r_inc_d    <= 1'b0;
      r_dec_q    <= 1'b0;
      r_dec_d    <= 1'b0;
      r_rep_cnt  <= '0;
      r_idle     <= '0;
      r_pre_hour <= '0;
      r_pre_min  <= '0;
      r_pre_sec  <= '0;
      r_pe       <= 1'b0;
      r_run_en   <= 1'b1;
      r_edit     <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode_q   <= mode_btn;
      r_mode_d   <= r_mode_q;
      r_inc_q    <= inc_btn;
      r_inc_d    <= r_inc_q;
      r_dec_q    <= dec_btn;
      r_dec_d    <= r_dec_q;
      r_rep_cnt  <= w_rep_nxt;
      r_idle     <= w_idle_nxt;
      r_pre_hour <= w_hour_nxt;
      r_pre_min  <= w_min_nxt;
      r_pre_sec  <= w_sec_nxt;
      r_pe       <= w_pe_nxt;
      r_run_en   <= w_run_en_nxt;
      r_edit     <= w_edit_nxt;
    end
  end

  assign pre_hour   = r_pre_hour;
  assign pre_min    = r_pre_min;
  assign pre_sec    = r_pre_sec;
  assign PE         = r_pe;
  assign run_en     = r_run_en;
  assign edit_field = r_edit;

endmodule
